// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin I/D cache line arbiter onto a 4-beat 64-bit burst port
module cache_mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req_read,
    input  logic [31:0]  i_req_addr,
    output logic [255:0] i_line_rdata,
    output logic         i_req_resp,
    input  logic         d_req_read,
    input  logic         d_req_write,
    input  logic [31:0]  d_req_addr,
    input  logic [255:0] d_line_wdata,
    output logic [255:0] d_line_rdata,
    output logic         d_req_resp,
    input  logic [63:0]  mem_rdata,
    input  logic         mem_resp,
    output logic [63:0]  mem_wdata,
    output logic [31:0]  mem_address,
    output logic         mem_read,
    output logic         mem_write
);

    typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_e;

    state_e         state_q, state_d;
    logic           last_d_q, last_d_d;
    logic           gnt_d_q, gnt_d_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   wline_q, wline_d;
    logic [255:0]   rline_q, rline_d;
    logic [1:0]     beat_q, beat_d;

    logic           i_pend, d_pend, pick_d;
    logic [31:0]    sel_addr;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^{i_req_addr[4:0], d_req_addr[4:0]};

    // On a tie the side that did not win last time is granted.
    assign i_pend   = i_req_read;
    assign d_pend   = d_req_read | d_req_write;
    assign pick_d   = d_pend && (!i_pend || !last_d_q);
    assign sel_addr = pick_d ? d_req_addr : i_req_addr;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        gnt_d_d  = gnt_d_q;
        addr_d   = addr_q;
        wline_d  = wline_q;
        rline_d  = rline_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    last_d_d = pick_d;
                    gnt_d_d  = pick_d;
                    beat_d   = 2'd0;
                    addr_d   = {sel_addr[31:5], 5'b0};
                    if (pick_d) begin
                        if (d_req_write) begin
                            state_d = D_WRITE;
                            wline_d = d_line_wdata;
                        end else begin
                            state_d = D_READ;
                        end
                    end else begin
                        state_d = I_READ;
                    end
                end
            end
            I_READ, D_READ, D_WRITE: begin
                if (mem_resp) begin
                    beat_d = beat_q + 2'd1;
                    if (state_q != D_WRITE) begin
                        rline_d[{beat_q, 6'b0} +: 64] = mem_rdata;
                    end
                    if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            gnt_d_q  <= 1'b0;
            addr_q   <= '0;
            wline_q  <= '0;
            rline_q  <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            gnt_d_q  <= gnt_d_d;
            addr_q   <= addr_d;
            wline_q  <= wline_d;
            rline_q  <= rline_d;
            beat_q   <= beat_d;
        end
    end

    // Burst strobes and responses decode straight from registered state.
    assign mem_read     = (state_q == I_READ) || (state_q == D_READ);
    assign mem_write    = (state_q == D_WRITE);
    assign mem_address  = addr_q;
    assign mem_wdata    = (state_q == D_WRITE) ? wline_q[{beat_q, 6'b0} +: 64] : 64'd0;
    assign i_req_resp   = (state_q == DONE) && !gnt_d_q;
    assign d_req_resp   = (state_q == DONE) && gnt_d_q;
    assign i_line_rdata = rline_q;
    assign d_line_rdata = rline_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_req_read = 1'b0;
    logic [31:0]  i_req_addr = '0;
    logic [255:0] i_line_rdata;
    logic         i_req_resp;
    logic         d_req_read = 1'b0;
    logic         d_req_write = 1'b0;
    logic [31:0]  d_req_addr = '0;
    logic [255:0] d_line_wdata = '0;
    logic [255:0] d_line_rdata;
    logic         d_req_resp;
    logic [63:0]  mem_rdata;
    logic         mem_resp;
    logic [63:0]  mem_wdata;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req_read(i_req_read), .i_req_addr(i_req_addr),
        .i_line_rdata(i_line_rdata), .i_req_resp(i_req_resp),
        .d_req_read(d_req_read), .d_req_write(d_req_write),
        .d_req_addr(d_req_addr), .d_line_wdata(d_line_wdata),
        .d_line_rdata(d_line_rdata), .d_req_resp(d_req_resp),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_wdata(mem_wdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct { bit is_d; bit is_wr; logic [255:0] line; } resp_t;
    typedef struct { bit is_wr; logic [31:0] addr; logic [255:0] wline; } burst_t;
    resp_t  rq[$];
    burst_t bq[$];

    function automatic logic [63:0] beat_val(logic [31:0] a, int k);
        if (a == 32'h0000_1220) return {16{4'(k + 1)}};
        return {a, 24'hC0FFEE, 8'(k)};
    endfunction

    function automatic logic [255:0] line_of(logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = beat_val(a, k);
        return l;
    endfunction

    function automatic void exp_burst(bit wr, logic [31:0] a, logic [255:0] wl);
        burst_t b;
        b.is_wr = wr; b.addr = a; b.wline = wl;
        bq.push_back(b);
    endfunction

    function automatic void exp_resp(bit is_d, bit wr, logic [255:0] l);
        resp_t r;
        r.is_d = is_d; r.is_wr = wr; r.line = l;
        rq.push_back(r);
    endfunction

    // Memory model: per-beat wait gaps, drives beats, checks burst address/kind/wdata.
    int     cyc = 0;
    int     gaps[4] = '{0, 0, 0, 0};
    bit     inj = 1'b0;
    bit     abort_ok = 1'b0;
    int     mbeat = 0;
    int     mgap = 0;
    bit     mburst = 1'b0;
    burst_t cur;
    int     last_ack = -10;
    int     burst_start = 0;
    int     ack_cyc[4];

    initial begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_resp = 1'b0;
            if (inj) begin
                mem_resp  = 1'b1;
                mem_rdata = '1;
            end else if (mem_read || mem_write) begin
                if (!mburst) begin
                    mburst = 1'b1; mbeat = 0; mgap = gaps[0]; burst_start = cyc;
                    if (bq.size() == 0) chk("burst_unexpected", 1, 0);
                    else begin
                        cur = bq.pop_front();
                        chk("burst_addr", mem_address, cur.addr);
                    end
                end
                chk("burst_kind", {mem_read, mem_write}, cur.is_wr ? 2'b01 : 2'b10);
                if (mgap > 0) mgap--;
                else if (mbeat < 4) begin
                    mem_resp  = 1'b1;
                    mem_rdata = beat_val(mem_address, mbeat);
                    if (mem_write) chk("wdata_beat", mem_wdata, cur.wline[64*mbeat +: 64]);
                    ack_cyc[mbeat] = cyc - burst_start + 1;
                    last_ack = cyc;
                    mbeat++;
                    if (mbeat < 4) mgap = gaps[mbeat];
                end
            end else if (mburst) begin
                mburst = 1'b0;
                if (!abort_ok) chk("burst_beats", mbeat, 4);
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (i_req_resp || d_req_resp) begin
                chk("resp_onehot", i_req_resp & d_req_resp, 0);
                chk("resp_mem_idle", {mem_read, mem_write}, 2'b00);
                chk("resp_latency", cyc, last_ack + 1);
                if (rq.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    e = rq.pop_front();
                    chk("resp_side", d_req_resp, e.is_d);
                    if (!e.is_wr) chk("resp_line", e.is_d ? d_line_rdata : i_line_rdata, e.line);
                end
            end
        end
    end

    task automatic run(input int maxc);
        int n = 0;
        while ((i_req_read || d_req_read || d_req_write) && n < maxc) begin
            @(negedge clk);
            n++;
            if (i_req_resp) i_req_read = 1'b0;
            if (d_req_resp) begin d_req_read = 1'b0; d_req_write = 1'b0; end
        end
        if (n >= maxc) begin
            chk("timeout", 1, 0);
            i_req_read = 1'b0; d_req_read = 1'b0; d_req_write = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {i_req_resp, d_req_resp, mem_read, mem_write, mem_address, mem_wdata}, '0);
        chk({name, "_lines"}, i_line_rdata | d_line_rdata, '0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [255:0] wl;
        int n;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] wl;
        int n;
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset_state");
        rst = 1'b1;

        // I-side only, zero wait
        gaps = '{0, 0, 0, 0};
        exp_burst(0, 32'h0000_1220, '0);
        exp_resp(0, 0, 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        i_req_addr = 32'h0000_1234; i_req_read = 1'b1;
        run(40);

        // D writeback, acks at burst cycles 3,5,6,10
        gaps = '{2, 1, 0, 3};
        wl = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
        exp_burst(1, 32'h0000_8040, wl);
        exp_resp(1, 1, '0);
        d_req_addr = 32'h0000_805F; d_line_wdata = wl; d_req_write = 1'b1;
        run(60);
        chk("ack_cycle0", ack_cyc[0], 3);
        chk("ack_cycle1", ack_cyc[1], 5);
        chk("ack_cycle2", ack_cyc[2], 6);
        chk("ack_cycle3", ack_cyc[3], 10);

        // mem_resp injected in IDLE after reset
        do_reset();
        inj = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2 chk_all_zero("idle_inject");
        end
        inj = 1'b0;

        // Tie from reset: D then I, then again D then I
        gaps = '{0, 0, 0, 0};
        exp_burst(0, 32'h0000_3000, '0); exp_resp(1, 0, line_of(32'h0000_3000));
        exp_burst(0, 32'h0000_2000, '0); exp_resp(0, 0, line_of(32'h0000_2000));
        i_req_addr = 32'h0000_2000; d_req_addr = 32'h0000_3000;
        i_req_read = 1'b1; d_req_read = 1'b1;
        run(60);
        exp_burst(0, 32'h0000_5000, '0); exp_resp(1, 0, line_of(32'h0000_5000));
        exp_burst(0, 32'h0000_4000, '0); exp_resp(0, 0, line_of(32'h0000_4000));
        i_req_addr = 32'h0000_4000; d_req_addr = 32'h0000_5000;
        i_req_read = 1'b1; d_req_read = 1'b1;
        run(60);

        // Read and write both high: write wins
        gaps = '{1, 0, 2, 0};
        wl = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'hA5A5_5A5A_A5A5_5A5A, 64'h0F0F_F0F0_0F0F_F0F0};
        exp_burst(1, 32'h0000_6000, wl);
        exp_resp(1, 1, '0);
        d_req_addr = 32'h0000_6008; d_line_wdata = wl;
        d_req_read = 1'b1; d_req_write = 1'b1;
        run(60);

        // Tie after a D grant: I wins
        gaps = '{0, 1, 0, 0};
        exp_burst(0, 32'h0000_7000, '0); exp_resp(0, 0, line_of(32'h0000_7000));
        exp_burst(0, 32'h0000_7100, '0); exp_resp(1, 0, line_of(32'h0000_7100));
        i_req_addr = 32'h0000_7000; d_req_addr = 32'h0000_7100;
        i_req_read = 1'b1; d_req_read = 1'b1;
        run(60);

        // Reset after beat 2 of an I read
        gaps = '{0, 0, 0, 0};
        exp_burst(0, 32'h0000_9000, '0);
        i_req_addr = 32'h0000_9000; i_req_read = 1'b1;
        n = 0;
        while (n < 20 && !(mburst && mbeat >= 2)) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reached_beat2", mbeat >= 2, 1);
        abort_ok = 1'b1;
        rst = 1'b0;
        #1;
        chk("abort_mem_read", mem_read, 0);
        chk("abort_no_resp", i_req_resp, 0);
        chk("abort_addr", mem_address, 0);
        i_req_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        abort_ok = 1'b0;
        exp_burst(0, 32'h0000_A0C0, '0); exp_resp(1, 0, line_of(32'h0000_A0C0));
        d_req_addr = 32'h0000_A0C7; d_req_read = 1'b1;
        run(40);

        chk("resp_queue_empty", rq.size(), 0);
        chk("burst_queue_empty", bq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
